// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master between NUM_REQ requesters.
// Issues one command at a time, tracks the bus phases and returns a done pulse with read data.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      transfer,
    output logic [ADDR_W-1:0]         addr_in,
    output logic [DATA_W-1:0]         data_in,
    output logic                      write_en,
    input  logic                      pselx,
    input  logic                      penable,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                cmd_write_q, cmd_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [IDW-1:0]      cand_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Scan starts just after the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_write_d  = cmd_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        req_ready    = '0;
        rsp_valid    = '0;
        transfer     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    cmd_addr_d   = addr_arr[win_idx];
                    cmd_wdata_d  = wdata_arr[win_idx];
                    cmd_write_d  = req_write[win_idx];
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                transfer = 1'b1;
                if (pselx && !penable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // transfer dropped here so the master idles after this single access.
                if (pselx && penable && pready) begin
                    rsp_rdata_d = prdata;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid[grant_id_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_write_q  <= cmd_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign addr_in   = cmd_addr_q;
    assign data_in   = cmd_wdata_q;
    assign write_en  = cmd_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master between NUM_REQ independent requesters (CPU shim, DMA, debug port, etc.).
- Accepts one command at a time using round-robin arbitration and drives the master's command inputs (transfer, addr_in, data_in, write_en).
- Watches the APB bus phase signals to detect completion, then returns read data and a done pulse to the winning requester.
- Sits between the requester fabric and the APB master; owns all sequencing of the master.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- IDW, $clog2(NUM_REQ): width of the requester index.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  per-requester direction (1 = write)
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same slicing rule
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_W  read data; meaningful only while rsp_valid != 0
transfer  out  1  command request to the APB master
addr_in  out  ADDR_W  command address to the master
data_in  out  DATA_W  command write data to the master
write_en  out  1  command direction to the master
pselx  in  1  APB select, observed from the bus
penable  in  1  APB enable, observed from the bus
pready  in  1  APB ready from the slave
prdata  in  DATA_W  APB read data from the slave
busy  out  1  high in every state except IDLE
grant_id  out  IDW  index of the requester currently owning the master

Behaviour:
- Reset state: FSM = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset output values: transfer = 0, addr_in = 0, data_in = 0, write_en = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, grant_id = 0.
- Reset mid-operation: all state, registers and outputs return to the reset values immediately. No response is issued for the in-flight command.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is high, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Combinationally assert req_ready for the winner in the same cycle.
  - On the clock edge: capture addr/wdata/write into cmd registers, set grant_id and last_grant to the winner, go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - transfer = 1; addr_in, data_in and write_en driven from the cmd registers.
  - Go to WAIT when pselx = 1 and penable = 0 (setup phase observed). Otherwise stay in ISSUE.
- WAIT:
  - transfer = 0, so the master returns to idle after the access.
  - Command outputs stay held from the cmd registers.
  - When pselx & penable & pready: capture prdata into rsp_rdata (writes capture it too; the value is don't-care) and go to DONE.
  - No timeout: wait indefinitely while pready = 0.
- DONE:
  - rsp_valid[grant_id] = 1 for exactly one cycle; rsp_rdata holds its captured value.
  - Go to IDLE.
  - rsp_rdata keeps its value until the next capture.
- Fixed latency with pready=1 on the first access cycle:
  - accept edge → ISSUE (1 cycle) → SETUP observed (1 cycle) → ACCESS done (1 cycle) → rsp_valid.
  - rsp_valid therefore rises 4 cycles after the req_ready cycle.
  - The next accept is possible in the cycle after DONE.
- Requester rule: req_valid and its payload must stay stable until req_ready. The arbiter samples them only in the req_ready cycle.
- Simultaneous events:
  - Several requesters valid: exactly one req_ready bit per accept; the others wait.
  - A requester re-asserting valid in the cycle after its own DONE loses to any other pending requester (round-robin).
- Only one outstanding command exists at any time.
- busy = 1 in ISSUE, WAIT and DONE.

Test Plan:
- Single write: requester 2 sends addr=0x0000_1000, wdata=0xDEAD_BEEF, write=1; slave pready=1.
  - Required: req_ready[2] pulses once.
  - Required: transfer high for 2 cycles, addr_in=0x1000 stable through the setup phase.
  - Required: rsp_valid=4'b0100 exactly 4 cycles after req_ready.
- Read with wait states: requester 0 reads 0x20; pready held 0 for 3 ACCESS cycles, then 1 with prdata=0x1234_5678.
  - Required: rsp_valid[0] pulses the cycle after the pready cycle.
  - Required: rsp_rdata=0x1234_5678; transfer=0 throughout WAIT.
- Round-robin: all 4 req_valid held high from reset, each dropped after its own req_ready.
  - Required: grant order 0,1,2,3; then re-raise 1 and 3 together → order 3,1 is wrong, 1 then 3 is required (last_grant=3, so the scan starts at 0).
- Fairness under contention: requesters 0 and 1 continuously valid.
  - Required: grants alternate 0,1,0,1; no requester is granted twice in a row while the other is pending.
- Reset mid-WAIT: assert rst_n=0 while in WAIT with pready=0.
  - Required: next sample shows busy=0, transfer=0, rsp_valid=0.
  - Required: after release, requester 0 wins first when all requesters are valid.
- Idle stability: no req_valid for 20 cycles.
  - Required: transfer, busy, req_ready and rsp_valid remain 0; grant_id is unchanged.
